sd_drive_arbiter: RTL and testbench



---
 rtl/sd_drive_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sd_drive_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_drive_arbiter.sv
// sd_drive_arbiter: shares the single mist_io SD block interface between
// NUM_DRIVES wd1793 instances. Round-robin grant, LBA latch, one-hot request
// generation, ack/buffer-write routing, per-drive image-ready flags and an
// acknowledge watchdog that abandons requests mist_io never answers.
module sd_drive_arbiter #(
    parameter int          NUM_DRIVES  = 2,
    parameter logic [23:0] ACK_TIMEOUT = 24'd4800000,
    parameter int          IDX_W       = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic [NUM_DRIVES-1:0]   img_mounted,
    output logic [NUM_DRIVES-1:0]   drv_ready,
    input  logic [32*NUM_DRIVES-1:0] drv_lba,
    input  logic [NUM_DRIVES-1:0]   drv_rd,
    input  logic [NUM_DRIVES-1:0]   drv_wr,
    input  logic [8*NUM_DRIVES-1:0] drv_buff_din,
    output logic [NUM_DRIVES-1:0]   drv_ack,
    output logic [NUM_DRIVES-1:0]   drv_buff_wr,
    output logic [31:0]             sd_lba,
    output logic [NUM_DRIVES-1:0]   sd_rd,
    output logic [NUM_DRIVES-1:0]   sd_wr,
    input  logic                    sd_ack,
    input  logic                    sd_buff_wr,
    output logic [7:0]              sd_buff_din,
    output logic [IDX_W-1:0]        grant,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Last drive served resets to the highest index so drive 0 wins first.
    localparam logic [IDX_W-1:0] LAST_GRANT_RST = IDX_W'(NUM_DRIVES - 1);
    localparam logic [23:0]      WD_LAST        = ACK_TIMEOUT - 24'd1;

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [31:0]           sd_lba_q, sd_lba_d;
    logic                  dir_rd_q, dir_rd_d;
    logic [23:0]           wd_cnt_q, wd_cnt_d;
    logic                  timeout_q, timeout_d;
    logic [NUM_DRIVES-1:0] mnt_s_q, mnt_s_d;
    logic [NUM_DRIVES-1:0] mnt_h_q, mnt_h_d;
    logic [NUM_DRIVES-1:0] ready_q, ready_d;

    logic [NUM_DRIVES-1:0] pending;
    logic                  scan_found;
    logic [IDX_W-1:0]      scan_idx;
    int                    scan_sum;
    logic                  req_live;
    logic                  xfer_act;

    logic [31:0] lba_arr [NUM_DRIVES];
    logic [7:0]  din_arr [NUM_DRIVES];

    assign pending  = drv_rd | drv_wr;
    assign xfer_act = (state_q == S_REQ) || (state_q == S_XFER);

    // Per-drive unpacking of the flat buses plus request/ack routing.
    for (genvar gi = 0; gi < NUM_DRIVES; gi++) begin : g_drv
        assign lba_arr[gi]     = drv_lba[32*gi +: 32];
        assign din_arr[gi]     = drv_buff_din[8*gi +: 8];
        assign sd_rd[gi]       = xfer_act &  dir_rd_q & (grant_q == IDX_W'(gi));
        assign sd_wr[gi]       = xfer_act & ~dir_rd_q & (grant_q == IDX_W'(gi));
        assign drv_ack[gi]     = xfer_act & sd_ack     & (grant_q == IDX_W'(gi));
        assign drv_buff_wr[gi] = xfer_act & sd_buff_wr & (grant_q == IDX_W'(gi));
    end

    assign sd_buff_din = din_arr[grant_q];
    assign sd_lba      = sd_lba_q;
    assign grant       = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_q;
    assign drv_ready   = ready_q;

    // Round-robin scan starting after the last served drive.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        scan_sum   = 0;
        for (int k = 1; k <= NUM_DRIVES; k++) begin
            scan_sum = int'(last_grant_q) + k;
            if (scan_sum >= NUM_DRIVES) begin
                scan_sum = scan_sum - NUM_DRIVES;
            end
            if (!scan_found && pending[IDX_W'(scan_sum)]) begin
                scan_found = 1'b1;
                scan_idx   = IDX_W'(scan_sum);
            end
        end
    end

    // Arbiter FSM, watchdog and ready-flag next-state logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        sd_lba_d     = sd_lba_q;
        dir_rd_d     = dir_rd_q;
        wd_cnt_d     = wd_cnt_q;
        timeout_d    = 1'b0;
        req_live     = dir_rd_q ? drv_rd[grant_q] : drv_wr[grant_q];

        case (state_q)
            S_IDLE: begin
                if (scan_found) begin
                    grant_d  = scan_idx;
                    sd_lba_d = lba_arr[scan_idx];
                    dir_rd_d = drv_rd[scan_idx];
                    wd_cnt_d = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (sd_ack) begin
                    state_d = S_XFER;
                end else if (!req_live) begin
                    state_d = S_IDLE;
                end else if (wd_cnt_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 24'd1;
                end
            end
            S_XFER: begin
                if (!sd_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Two-flop rising-edge detect on the mount strobes; clr dominates.
        mnt_s_d = img_mounted;
        mnt_h_d = mnt_s_q;
        if (clr) begin
            ready_d = '0;
        end else begin
            ready_d = ready_q | (mnt_s_q & ~mnt_h_q);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_GRANT_RST;
            sd_lba_q     <= '0;
            dir_rd_q     <= 1'b0;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
            mnt_s_q      <= '0;
            mnt_h_q      <= '0;
            ready_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            sd_lba_q     <= sd_lba_d;
            dir_rd_q     <= dir_rd_d;
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
            mnt_s_q      <= mnt_s_d;
            mnt_h_q      <= mnt_h_d;
            ready_q      <= ready_d;
        end
    end

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Self-checking bench for sd_drive_arbiter with two drives and a short
// watchdog: a cycle-by-cycle vector table plus hand-written sequences.
module tb_sd_drive_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        clr;
    logic [1:0]  img_mounted;
    logic [1:0]  drv_ready;
    logic [31:0] lba0, lba1;
    logic [63:0] drv_lba;
    logic [1:0]  drv_rd, drv_wr;
    logic [15:0] drv_buff_din;
    logic [1:0]  drv_ack, drv_buff_wr;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd, sd_wr;
    logic        sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [0:0]  grant;
    logic        busy, timeout_err;

    int checks   = 0;
    int failures = 0;

    assign drv_lba      = {lba1, lba0};
    assign drv_buff_din = {8'hA5, 8'h3C};

    always #5 clk_sys = ~clk_sys;

    sd_drive_arbiter #(
        .NUM_DRIVES (2),
        .ACK_TIMEOUT(24'd16)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .clr         (clr),
        .img_mounted (img_mounted),
        .drv_ready   (drv_ready),
        .drv_lba     (drv_lba),
        .drv_rd      (drv_rd),
        .drv_wr      (drv_wr),
        .drv_buff_din(drv_buff_din),
        .drv_ack     (drv_ack),
        .drv_buff_wr (drv_buff_wr),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .sd_buff_wr  (sd_buff_wr),
        .sd_buff_din (sd_buff_din),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        ack;
        logic        bw;
        logic [31:0] l0;
        logic [1:0]  e_rd;
        logic [1:0]  e_wr;
        logic        e_grant;
        logic        e_busy;
        logic [31:0] e_lba;
        logic [1:0]  e_ack;
        logic [1:0]  e_bw;
        logic [7:0]  e_din;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        clr         = 1'b0;
        img_mounted = 2'b00;
        drv_rd      = 2'b00;
        drv_wr      = 2'b00;
        sd_ack      = 1'b0;
        sd_buff_wr  = 1'b0;
        lba0        = 32'h0;
        lba1        = 32'h0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    // Waits (bounded) for any request to appear; records both-high violations.
    task automatic wait_req(output bit ok, inout bit both_seen);
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk_sys);
            #1;
            if (sd_rd == 2'b11) both_seen = 1'b1;
            if ((sd_rd | sd_wr) != 2'b00) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        bit both;
        int cnt0, cnt1, kseen;
        logic [0:0] exp_g [3];

        //          rd    wr    ack   bw    lba0      e_rd  e_wr  g     busy  e_lba     e_ack e_bw  e_din
        vecs[0]  = '{2'b00,2'b00,1'b0,1'b0,32'h10, 2'b00,2'b00,1'b0,1'b0,32'h00, 2'b00,2'b00,8'h3C};
        vecs[1]  = '{2'b01,2'b00,1'b0,1'b0,32'h10, 2'b00,2'b00,1'b0,1'b0,32'h00, 2'b00,2'b00,8'h3C};
        vecs[2]  = '{2'b01,2'b00,1'b0,1'b0,32'h99, 2'b01,2'b00,1'b0,1'b1,32'h10, 2'b00,2'b00,8'h3C};
        vecs[3]  = '{2'b01,2'b00,1'b1,1'b1,32'h99, 2'b01,2'b00,1'b0,1'b1,32'h10, 2'b01,2'b01,8'h3C};
        vecs[4]  = '{2'b01,2'b00,1'b1,1'b0,32'h99, 2'b01,2'b00,1'b0,1'b1,32'h10, 2'b01,2'b00,8'h3C};
        vecs[5]  = '{2'b01,2'b00,1'b0,1'b0,32'h99, 2'b01,2'b00,1'b0,1'b1,32'h10, 2'b00,2'b00,8'h3C};
        vecs[6]  = '{2'b00,2'b00,1'b0,1'b0,32'h99, 2'b00,2'b00,1'b0,1'b1,32'h10, 2'b00,2'b00,8'h3C};
        vecs[7]  = '{2'b00,2'b10,1'b0,1'b0,32'h99, 2'b00,2'b00,1'b0,1'b0,32'h10, 2'b00,2'b00,8'h3C};
        vecs[8]  = '{2'b00,2'b10,1'b0,1'b0,32'h99, 2'b00,2'b10,1'b1,1'b1,32'h20, 2'b00,2'b00,8'hA5};
        vecs[9]  = '{2'b00,2'b10,1'b1,1'b0,32'h99, 2'b00,2'b10,1'b1,1'b1,32'h20, 2'b10,2'b00,8'hA5};
        vecs[10] = '{2'b00,2'b10,1'b1,1'b1,32'h99, 2'b00,2'b10,1'b1,1'b1,32'h20, 2'b10,2'b10,8'hA5};
        vecs[11] = '{2'b00,2'b10,1'b0,1'b0,32'h99, 2'b00,2'b10,1'b1,1'b1,32'h20, 2'b00,2'b00,8'hA5};
        vecs[12] = '{2'b00,2'b00,1'b0,1'b0,32'h99, 2'b00,2'b00,1'b1,1'b1,32'h20, 2'b00,2'b00,8'hA5};
        vecs[13] = '{2'b00,2'b00,1'b0,1'b0,32'h99, 2'b00,2'b00,1'b1,1'b0,32'h20, 2'b00,2'b00,8'hA5};
        vecs[14] = '{2'b01,2'b01,1'b0,1'b0,32'h99, 2'b00,2'b00,1'b1,1'b0,32'h20, 2'b00,2'b00,8'hA5};
        vecs[15] = '{2'b01,2'b01,1'b0,1'b0,32'h99, 2'b01,2'b00,1'b0,1'b1,32'h99, 2'b00,2'b00,8'h3C};
        vecs[16] = '{2'b00,2'b01,1'b0,1'b0,32'h99, 2'b01,2'b00,1'b0,1'b1,32'h99, 2'b00,2'b00,8'h3C};
        vecs[17] = '{2'b00,2'b00,1'b0,1'b0,32'h99, 2'b00,2'b00,1'b0,1'b0,32'h99, 2'b00,2'b00,8'h3C};
        vecs[18] = '{2'b11,2'b00,1'b0,1'b0,32'h99, 2'b00,2'b00,1'b0,1'b0,32'h99, 2'b00,2'b00,8'h3C};
        vecs[19] = '{2'b11,2'b00,1'b0,1'b0,32'h99, 2'b01,2'b00,1'b0,1'b1,32'h99, 2'b00,2'b00,8'h3C};

        // Reset state, sampled while reset is held.
        reset_n = 1'b0;
        clr = 1'b0; img_mounted = 2'b00; drv_rd = 2'b00; drv_wr = 2'b00;
        sd_ack = 1'b0; sd_buff_wr = 1'b0; lba0 = 32'h0; lba1 = 32'h20;
        #12;
        check("rst_sd_rd", 32'(sd_rd), 32'h0);
        check("rst_sd_wr", 32'(sd_wr), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_sd_lba", sd_lba, 32'h0);
        check("rst_ready", 32'(drv_ready), 32'h0);
        check("rst_timeout", 32'(timeout_err), 32'h0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // Cycle-by-cycle vector table.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_sys);
            drv_rd = vecs[i].rd; drv_wr = vecs[i].wr;
            sd_ack = vecs[i].ack; sd_buff_wr = vecs[i].bw; lba0 = vecs[i].l0;
            #1;
            check($sformatf("v%0d_sd_rd", i), 32'(sd_rd), 32'(vecs[i].e_rd));
            check($sformatf("v%0d_sd_wr", i), 32'(sd_wr), 32'(vecs[i].e_wr));
            check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_sd_lba", i), sd_lba, vecs[i].e_lba);
            check($sformatf("v%0d_drv_ack", i), 32'(drv_ack), 32'(vecs[i].e_ack));
            check($sformatf("v%0d_drv_bw", i), 32'(drv_buff_wr), 32'(vecs[i].e_bw));
            check($sformatf("v%0d_din", i), 32'(sd_buff_din), 32'(vecs[i].e_din));
            $display("vec %0d rd=%b wr=%b ack=%b sd_rd=%b sd_wr=%b grant=%0d busy=%b lba=%h",
                     i, drv_rd, drv_wr, sd_ack, sd_rd, sd_wr, grant, busy, sd_lba);
        end

        // Single 512-byte read on drive 0.
        do_reset();
        drv_rd = 2'b01; lba0 = 32'h10;
        @(negedge clk_sys); #1;
        check("rd_sd_rd_latency", 32'(sd_rd), 32'h1);
        check("rd_sd_lba", sd_lba, 32'h10);
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 512; i++) begin
            sd_ack = 1'b1; sd_buff_wr = 1'b1;
            #1;
            cnt0 += int'(drv_buff_wr[0]);
            cnt1 += int'(drv_buff_wr[1]);
            @(negedge clk_sys);
        end
        sd_ack = 1'b0; sd_buff_wr = 1'b0; drv_rd = 2'b00;
        #1;
        check("rd_sd_rd_ack_fall", 32'(sd_rd), 32'h1);
        @(negedge clk_sys); #1;
        check("rd_sd_rd_done", 32'(sd_rd), 32'h0);
        check("rd_busy_done", 32'(busy), 32'h1);
        check("rd_bw0_count", 32'(cnt0), 32'd512);
        check("rd_bw1_count", 32'(cnt1), 32'd0);
        $display("seq read512 bw0=%0d bw1=%0d", cnt0, cnt1);

        // Contention: both drives request continuously.
        do_reset();
        drv_rd = 2'b11;
        both = 1'b0;
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            wait_req(ok, both);
            check($sformatf("cont%0d_seen", t), 32'(ok), 32'h1);
            check($sformatf("cont%0d_grant", t), 32'(grant), 32'(exp_g[t]));
            check($sformatf("cont%0d_sd_rd", t), 32'(sd_rd), exp_g[t] ? 32'h2 : 32'h1);
            $display("seq contention %0d grant=%0d sd_rd=%b", t, grant, sd_rd);
            sd_ack = 1'b1;
            @(negedge clk_sys);
            if (sd_rd == 2'b11) both = 1'b1;
            sd_ack = 1'b0;
        end
        check("cont_both_high", 32'(both), 32'h0);
        drv_rd = 2'b00;

        // Watchdog: no acknowledge ever arrives.
        do_reset();
        drv_rd = 2'b01;
        @(negedge clk_sys); #1;
        check("to_sd_rd_rise", 32'(sd_rd), 32'h1);
        kseen = 0;
        for (int k = 1; k <= 30 && kseen == 0; k++) begin
            @(negedge clk_sys); #1;
            if (timeout_err) kseen = k;
        end
        check("to_pulse_cycle", 32'(kseen), 32'd16);
        check("to_sd_rd_drop", 32'(sd_rd), 32'h0);
        check("to_busy_drop", 32'(busy), 32'h0);
        drv_rd = 2'b00;
        @(negedge clk_sys); #1;
        check("to_pulse_width", 32'(timeout_err), 32'h0);
        $display("seq timeout seen_at=%0d", kseen);

        // Ready flags and clear.
        do_reset();
        img_mounted = 2'b10;
        #1;
        check("rdy_before", 32'(drv_ready), 32'h0);
        @(negedge clk_sys);
        img_mounted = 2'b00;
        #1;
        check("rdy_sampled", 32'(drv_ready), 32'h0);
        @(negedge clk_sys); #1;
        check("rdy_set1", 32'(drv_ready), 32'h2);
        clr = 1'b1; img_mounted = 2'b01;
        @(negedge clk_sys);
        @(negedge clk_sys);
        clr = 1'b0;
        #1;
        check("rdy_clr_wins", 32'(drv_ready), 32'h0);
        @(negedge clk_sys); #1;
        check("rdy_clr_hold", 32'(drv_ready), 32'h0);
        $display("seq ready drv_ready=%b", drv_ready);
        img_mounted = 2'b00;

        // Asynchronous reset in the middle of a transfer on drive 1.
        do_reset();
        lba1 = 32'h20;
        drv_rd = 2'b10;
        both = 1'b0;
        wait_req(ok, both);
        check("ar_granted", 32'(grant), 32'h1);
        sd_ack = 1'b1; sd_buff_wr = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_sd_rd", 32'(sd_rd), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_drv_ack", 32'(drv_ack), 32'h0);
        check("ar_drv_bw", 32'(drv_buff_wr), 32'h0);
        check("ar_grant", 32'(grant), 32'h0);
        check("ar_sd_lba", sd_lba, 32'h0);
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        drv_rd = 2'b11;
        wait_req(ok, both);
        check("ar_seen", 32'(ok), 32'h1);
        check("ar_first_grant", 32'(grant), 32'h0);
        $display("seq async_reset grant_after=%0d", grant);
        drv_rd = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
